// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Control-bit positions and named control codes for the
//               Hack-compatible pipelined ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int CTRL_W  = 6;

    localparam int CTRL_ZX = 5;
    localparam int CTRL_NX = 4;
    localparam int CTRL_ZY = 3;
    localparam int CTRL_NY = 2;
    localparam int CTRL_F  = 1;
    localparam int CTRL_NO = 0;

    localparam logic [CTRL_W-1:0] ALU_ZERO  = 6'b101010;
    localparam logic [CTRL_W-1:0] ALU_ONE   = 6'b111111;
    localparam logic [CTRL_W-1:0] ALU_NEG1  = 6'b111010;
    localparam logic [CTRL_W-1:0] ALU_XPY   = 6'b000010;
    localparam logic [CTRL_W-1:0] ALU_XMY   = 6'b010011;
    localparam logic [CTRL_W-1:0] ALU_XANDY = 6'b000000;

endpackage
`default_nettype wire

// File: rtl/alu_pipe_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe_core
// Description : Combinational ALU function on preprocessed operands; produces
//               result and zr/ng/co/ov flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe_core #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] xp,
    input  logic [WIDTH-1:0] yp,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             co,
    output logic             ov
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_r;

    always_comb begin
        w_sum = {1'b0, xp} + {1'b0, yp};
        w_r   = f ? w_sum[WIDTH-1:0] : (xp & yp);
        out   = no ? ~w_r : w_r;
        zr    = (out == '0);
        ng    = out[WIDTH-1];
        // Adder flags describe x'+y' before the output inversion
        co    = f & w_sum[WIDTH];
        ov    = f & (xp[WIDTH-1] == yp[WIDTH-1]) & (w_sum[WIDTH-1] != xp[WIDTH-1]);
    end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Two-stage pipelined Hack ALU with valid/ready handshakes on
//               both sides; S1 holds preprocessed operands, S2 the result.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             co,
    output logic             ov
);
    import alu_pkg::*;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_x;
    logic [WIDTH-1:0] r_s1_y;
    logic             r_s1_f;
    logic             r_s1_no;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out;
    logic             r_zr;
    logic             r_ng;
    logic             r_co;
    logic             r_ov;

    logic [WIDTH-1:0] w_xp;
    logic [WIDTH-1:0] w_yp;
    logic             w_s1_adv;
    logic             w_s2_adv;
    logic [WIDTH-1:0] w_core_out;
    logic             w_core_zr;
    logic             w_core_ng;
    logic             w_core_co;
    logic             w_core_ov;

    // Zeroing happens before inversion, so zx+nx yields all-ones
    always_comb begin
        w_xp = ctrl[CTRL_ZX] ? '0 : x;
        if (ctrl[CTRL_NX]) w_xp = ~w_xp;
        w_yp = ctrl[CTRL_ZY] ? '0 : y;
        if (ctrl[CTRL_NY]) w_yp = ~w_yp;
    end

    assign w_s2_adv  = !r_out_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign in_ready  = w_s1_adv;

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign zr        = r_zr;
    assign ng        = r_ng;
    assign co        = r_co;
    assign ov        = r_ov;

    alu_pipe_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .xp  (r_s1_x),
        .yp  (r_s1_y),
        .f   (r_s1_f),
        .no  (r_s1_no),
        .out (w_core_out),
        .zr  (w_core_zr),
        .ng  (w_core_ng),
        .co  (w_core_co),
        .ov  (w_core_ov)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_zr        <= 1'b1;
            r_ng        <= 1'b0;
            r_co        <= 1'b0;
            r_ov        <= 1'b0;
        end else begin
            if (w_s1_adv) r_s1_valid <= in_valid;
            if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
                // A bubble only clears out_valid; the stale data is never presented
                if (r_s1_valid) begin
                    r_out <= w_core_out;
                    r_zr  <= w_core_zr;
                    r_ng  <= w_core_ng;
                    r_co  <= w_core_co;
                    r_ov  <= w_core_ov;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_s1_adv && in_valid) begin
            r_s1_x  <= w_xp;
            r_s1_y  <= w_yp;
            r_s1_f  <= ctrl[CTRL_F];
            r_s1_no <= ctrl[CTRL_NO];
        end
    end

endmodule
`default_nettype wire
